// File: rtl/frame_buf_pkg.sv
// Shared types and helpers for the triple-buffered frame buffer.
package frame_buf_pkg;

  // Bank index; three banks are in use, so two bits suffice.
  typedef logic [1:0] bank_t;

  localparam bank_t BANK0 = 2'd0;
  localparam bank_t BANK1 = 2'd1;
  localparam bank_t BANK2 = 2'd2;

  // Flat memory address width covering all three banks.
  function automatic int addr_width(input int frame_pixels);
    return $clog2(3 * frame_pixels);
  endfunction

  // Width of an in-frame pixel index.
  function automatic int pix_width(input int frame_pixels);
    return (frame_pixels > 1) ? $clog2(frame_pixels) : 1;
  endfunction

  // Increment that sticks at the all-ones value of a counter `width` bits wide.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/frame_buf_ram.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
module frame_buf_ram #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 12,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  // Write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; output holds when no read is enabled.
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/frame_buf_tb3.sv
// Triple-buffered frame buffer: bank rotation, pointers and drop/repeat counters.
module frame_buf_tb3
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH   = 24,
  parameter int FRAME_PIXELS = 307200,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_in,
  input  logic                  wr_sof_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic                  rd_sof_out,
  output logic                  frame_ready_out,
  output logic [CNT_WIDTH-1:0]  drop_cnt_out,
  output logic [CNT_WIDTH-1:0]  repeat_cnt_out
);

  localparam int PW    = pix_width(FRAME_PIXELS);
  localparam int AW    = addr_width(FRAME_PIXELS);
  localparam int DEPTH = 3 * FRAME_PIXELS;
  localparam logic [PW-1:0] LAST_PIX = PW'(FRAME_PIXELS - 1);

  bank_t                wr_bank_reg, rd_bank_reg, pend_bank_reg;
  bank_t                wr_bank_next, rd_bank_next, pend_bank_next;
  logic                 pend_valid_reg, pend_valid_next;
  logic [PW-1:0]        wr_addr_reg, wr_addr_next;
  logic [PW-1:0]        rd_addr_reg, rd_addr_next;
  logic                 frame_ready_reg;
  logic                 data_valid_reg, rd_sof_reg;
  logic [CNT_WIDTH-1:0] drop_cnt_reg, repeat_cnt_reg;

  logic [PW-1:0] wr_addr_eff;
  logic          wr_done;
  logic          rd_at_start, rd_accept, rd_swap, rd_repeat;
  logic          drop_inc;
  bank_t         rd_bank_eff;
  logic [AW-1:0] wr_mem_addr, rd_mem_addr;

  // Decode this cycle's write/read events; the reader only sees the registered pend_valid.
  always_comb begin
    wr_addr_eff = wr_sof_in ? '0 : wr_addr_reg;
    wr_done     = wr_en_in && (wr_addr_eff == LAST_PIX);
    rd_at_start = (rd_addr_reg == '0);
    rd_accept   = rd_en_in && !(rd_at_start && !pend_valid_reg && !frame_ready_reg);
    rd_swap     = rd_accept && rd_at_start && pend_valid_reg;
    rd_repeat   = rd_accept && rd_at_start && !pend_valid_reg;
    // On a handover the first pixel comes from the bank about to become rd_bank.
    rd_bank_eff = rd_swap ? pend_bank_reg : rd_bank_reg;
  end

  // Bank rotation: indices stay a permutation of 0,1,2 in every branch.
  always_comb begin
    wr_bank_next    = wr_bank_reg;
    rd_bank_next    = rd_bank_reg;
    pend_bank_next  = pend_bank_reg;
    pend_valid_next = pend_valid_reg;
    drop_inc        = 1'b0;
    if (wr_done && rd_swap) begin
      // Reader takes the old pending frame while the new one replaces it.
      rd_bank_next    = pend_bank_reg;
      pend_bank_next  = wr_bank_reg;
      wr_bank_next    = rd_bank_reg;
      pend_valid_next = 1'b1;
    end else if (wr_done) begin
      wr_bank_next    = pend_bank_reg;
      pend_bank_next  = wr_bank_reg;
      pend_valid_next = 1'b1;
      drop_inc        = pend_valid_reg;
    end else if (rd_swap) begin
      rd_bank_next    = pend_bank_reg;
      pend_bank_next  = rd_bank_reg;
      pend_valid_next = 1'b0;
    end
  end

  // Pixel pointers: write restarts on SOF, both wrap at frame end.
  always_comb begin
    wr_addr_next = wr_addr_reg;
    if (wr_en_in) begin
      wr_addr_next = wr_done ? '0 : wr_addr_eff + PW'(1);
    end else if (wr_sof_in) begin
      wr_addr_next = '0;
    end
    rd_addr_next = rd_addr_reg;
    if (rd_accept) begin
      rd_addr_next = (rd_addr_reg == LAST_PIX) ? '0 : rd_addr_reg + PW'(1);
    end
  end

  assign wr_mem_addr = AW'(wr_bank_reg) * AW'(FRAME_PIXELS) + AW'(wr_addr_eff);
  assign rd_mem_addr = AW'(rd_bank_eff) * AW'(FRAME_PIXELS) + AW'(rd_addr_reg);

  // State, flags and saturating counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_reg     <= BANK0;
      rd_bank_reg     <= BANK1;
      pend_bank_reg   <= BANK2;
      pend_valid_reg  <= 1'b0;
      wr_addr_reg     <= '0;
      rd_addr_reg     <= '0;
      frame_ready_reg <= 1'b0;
      data_valid_reg  <= 1'b0;
      rd_sof_reg      <= 1'b0;
      drop_cnt_reg    <= '0;
      repeat_cnt_reg  <= '0;
    end else begin
      wr_bank_reg    <= wr_bank_next;
      rd_bank_reg    <= rd_bank_next;
      pend_bank_reg  <= pend_bank_next;
      pend_valid_reg <= pend_valid_next;
      wr_addr_reg    <= wr_addr_next;
      rd_addr_reg    <= rd_addr_next;
      data_valid_reg <= rd_accept;
      rd_sof_reg     <= rd_accept && rd_at_start;
      if (rd_swap) begin
        frame_ready_reg <= 1'b1;
      end
      if (drop_inc) begin
        drop_cnt_reg <= CNT_WIDTH'(sat_inc(32'(drop_cnt_reg), CNT_WIDTH));
      end
      if (rd_repeat) begin
        repeat_cnt_reg <= CNT_WIDTH'(sat_inc(32'(repeat_cnt_reg), CNT_WIDTH));
      end
    end
  end

  frame_buf_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_ram (
    .clk    (clk),
    .srst   (reset),
    .wr_en  (wr_en_in),
    .wr_addr(wr_mem_addr),
    .wr_data(data_in),
    .rd_en  (rd_accept),
    .rd_addr(rd_mem_addr),
    .rd_data(data_out)
  );

  assign data_valid_out  = data_valid_reg;
  assign rd_sof_out      = rd_sof_reg;
  assign frame_ready_out = frame_ready_reg;
  assign drop_cnt_out    = drop_cnt_reg;
  assign repeat_cnt_out  = repeat_cnt_reg;

endmodule

// File: tb/tb_frame_buf_tb3.sv
// Self-checking bench for frame_buf_tb3 with FRAME_PIXELS=4; a second instance uses 2-bit counters.
module tb_frame_buf_tb3;

  localparam int N  = 4;
  localparam int DW = 24;

  logic          clk;
  logic          reset;
  logic          wr_en_in, wr_sof_in, rd_en_in;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out, s_data_out;
  logic          data_valid_out, rd_sof_out, frame_ready_out;
  logic          s_data_valid_out, s_rd_sof_out, s_frame_ready_out;
  logic [15:0]   drop_cnt_out, repeat_cnt_out;
  logic [1:0]    s_drop_cnt_out, s_repeat_cnt_out;

  int n_tests = 0;
  int n_fail  = 0;

  frame_buf_tb3 #(.DATA_WIDTH(DW), .FRAME_PIXELS(N), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .wr_en_in(wr_en_in), .wr_sof_in(wr_sof_in), .data_in(data_in),
    .rd_en_in(rd_en_in), .data_out(data_out), .data_valid_out(data_valid_out),
    .rd_sof_out(rd_sof_out), .frame_ready_out(frame_ready_out),
    .drop_cnt_out(drop_cnt_out), .repeat_cnt_out(repeat_cnt_out)
  );

  frame_buf_tb3 #(.DATA_WIDTH(DW), .FRAME_PIXELS(N), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .reset(reset), .wr_en_in(wr_en_in), .wr_sof_in(wr_sof_in), .data_in(data_in),
    .rd_en_in(rd_en_in), .data_out(s_data_out), .data_valid_out(s_data_valid_out),
    .rd_sof_out(s_rd_sof_out), .frame_ready_out(s_frame_ready_out),
    .drop_cnt_out(s_drop_cnt_out), .repeat_cnt_out(s_repeat_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level reference model: whole frames move between "being written",
  // "pending" and "on display"; the reader consumes before the writer publishes.
  logic [DW-1:0] m_wfr  [N];
  logic [DW-1:0] m_pend [N];
  logic [DW-1:0] m_disp [N];
  int            m_wpos, m_rpos, m_drop, m_rep;
  bit            m_pv, m_ready, m_valid, m_sof;
  logic [DW-1:0] m_data;

  task automatic model_step(input bit we, input bit ws, input logic [DW-1:0] d, input bit re, input bit rst);
    bit accept;
    if (rst) begin
      m_wpos = 0; m_rpos = 0; m_drop = 0; m_rep = 0;
      m_pv = 0; m_ready = 0; m_valid = 0; m_sof = 0; m_data = '0;
      return;
    end
    accept = re && !(m_rpos == 0 && !m_pv && !m_ready);
    if (accept) begin
      if (m_rpos == 0) begin
        if (m_pv) begin
          m_disp = m_pend; m_pv = 0; m_ready = 1;
        end else begin
          m_rep++;
        end
      end
      m_data  = m_disp[m_rpos];
      m_sof   = (m_rpos == 0);
      m_valid = 1;
      m_rpos  = (m_rpos + 1) % N;
    end else begin
      m_valid = 0; m_sof = 0;
    end
    if (ws) m_wpos = 0;
    if (we) begin
      m_wfr[m_wpos] = d;
      if (m_wpos == N - 1) begin
        if (m_pv) m_drop++;
        m_pend = m_wfr; m_pv = 1; m_wpos = 0;
      end else begin
        m_wpos++;
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, settle 1 time unit after it.
  task automatic tick(input bit we, input bit ws, input logic [DW-1:0] d, input bit re, input bit rst);
    wr_en_in = we; wr_sof_in = ws; data_in = d; rd_en_in = re; reset = rst;
    @(posedge clk);
    model_step(we, ws, d, re, rst);
    #1;
  endtask

  task automatic do_reset();
    tick(0, 0, '0, 0, 1);
    tick(0, 0, '0, 0, 1);
  endtask

  task automatic test_reset();
    tick(0, 0, '0, 1, 1);
    tick(0, 0, '0, 1, 1);
    n_tests++;
    if ({data_out, data_valid_out, rd_sof_out, frame_ready_out, drop_cnt_out, repeat_cnt_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%0d valid=%0b sof=%0b ready=%0b drop=%0d rep=%0d, expected all 0",
               data_out, data_valid_out, rd_sof_out, frame_ready_out, drop_cnt_out, repeat_cnt_out);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, '0, 1, 0);
      n_tests++;
      if (data_valid_out !== 1'b0 || frame_ready_out !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_refused[%0d]: got valid=%0b ready=%0b, expected valid=0 ready=0", i, data_valid_out, frame_ready_out);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < N; i++) tick(1, 0, DW'(i + 1), 0, 0);
    for (int i = 0; i < 2 * N; i++) begin
      tick(0, 0, '0, 1, 0);
      n_tests++;
      if (data_valid_out !== 1'b1 || data_out !== DW'(i % N + 1) || rd_sof_out !== (i % N == 0) || frame_ready_out !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_read[%0d]: got valid=%0b data=%0d sof=%0b ready=%0b, expected valid=1 data=%0d sof=%0b ready=1",
                 i, data_valid_out, data_out, rd_sof_out, frame_ready_out, i % N + 1, (i % N == 0));
      end
    end
    n_tests++;
    if (repeat_cnt_out !== 16'd1 || drop_cnt_out !== 16'd0) begin
      n_fail++;
      $display("FAIL basic_counters: got rep=%0d drop=%0d, expected rep=1 drop=0", repeat_cnt_out, drop_cnt_out);
    end
    tick(0, 0, '0, 0, 0);
    n_tests++;
    if (data_valid_out !== 1'b0 || data_out !== DW'(N)) begin
      n_fail++;
      $display("FAIL basic_idle: got valid=%0b data=%0d, expected valid=0 data=%0d", data_valid_out, data_out, N);
    end
  endtask

  task automatic test_drop();
    do_reset();
    for (int i = 0; i < N; i++) tick(1, 0, DW'(10 + i), 0, 0);
    for (int i = 0; i < N; i++) tick(1, 0, DW'(20 + i), 0, 0);
    n_tests++;
    if (drop_cnt_out !== 16'd1) begin
      n_fail++;
      $display("FAIL drop_count: got %0d, expected 1", drop_cnt_out);
    end
    for (int i = 0; i < N; i++) begin
      tick(0, 0, '0, 1, 0);
      n_tests++;
      if (data_valid_out !== 1'b1 || data_out !== DW'(20 + i)) begin
        n_fail++;
        $display("FAIL drop_read[%0d]: got valid=%0b data=%0d, expected valid=1 data=%0d", i, data_valid_out, data_out, 20 + i);
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    tick(1, 0, DW'(5), 0, 0);
    tick(1, 0, DW'(6), 0, 0);
    tick(1, 1, DW'(7), 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, DW'(8 + i), 0, 0);
    for (int i = 0; i < N; i++) begin
      tick(0, 0, '0, 1, 0);
      n_tests++;
      if (data_valid_out !== 1'b1 || data_out !== DW'(7 + i) || rd_sof_out !== (i == 0)) begin
        n_fail++;
        $display("FAIL abort_read[%0d]: got valid=%0b data=%0d sof=%0b, expected valid=1 data=%0d sof=%0b",
                 i, data_valid_out, data_out, rd_sof_out, 7 + i, (i == 0));
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < N; i++) tick(1, 0, DW'(30 + i), 0, 0);
    for (int i = 0; i < N - 1; i++) tick(1, 0, DW'(40 + i), 0, 0);
    // Last pixel of 40..43 and the read-start handover of 30..33 share one edge.
    tick(1, 0, DW'(43), 1, 0);
    for (int i = 0; i < 2 * N; i++) begin
      if (i > 0) tick(0, 0, '0, 1, 0);
      n_tests++;
      if (data_valid_out !== 1'b1 || data_out !== DW'((i < N) ? 30 + i : 40 + i - N)) begin
        n_fail++;
        $display("FAIL simul_read[%0d]: got valid=%0b data=%0d, expected valid=1 data=%0d",
                 i, data_valid_out, data_out, (i < N) ? 30 + i : 40 + i - N);
      end
    end
    n_tests++;
    if (drop_cnt_out !== 16'd0 || repeat_cnt_out !== 16'd0) begin
      n_fail++;
      $display("FAIL simul_counters: got drop=%0d rep=%0d, expected drop=0 rep=0", drop_cnt_out, repeat_cnt_out);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < N; i++) tick(1, 0, DW'(50 + i), 0, 0);
    for (int i = 0; i < 6 * N; i++) tick(0, 0, '0, 1, 0);
    n_tests++;
    if (s_repeat_cnt_out !== 2'd3 || repeat_cnt_out !== 16'd5) begin
      n_fail++;
      $display("FAIL saturation: got rep2=%0d rep16=%0d, expected rep2=3 rep16=5", s_repeat_cnt_out, repeat_cnt_out);
    end
  endtask

  task automatic test_random();
    bit we, ws, re, rst;
    logic [DW-1:0] d;
    int e_drop16, e_rep16, e_drop2, e_rep2;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      we  = ($urandom_range(0, 99) < 65);
      ws  = ($urandom_range(0, 99) < 5);
      re  = ($urandom_range(0, 99) < 55);
      rst = ($urandom_range(0, 299) == 0);
      d   = DW'($urandom);
      tick(we, ws, d, re, rst);
      e_drop16 = (m_drop > 65535) ? 65535 : m_drop;
      e_rep16  = (m_rep  > 65535) ? 65535 : m_rep;
      e_drop2  = (m_drop > 3) ? 3 : m_drop;
      e_rep2   = (m_rep  > 3) ? 3 : m_rep;
      n_tests++;
      if (data_valid_out !== m_valid || rd_sof_out !== m_sof || data_out !== m_data || frame_ready_out !== m_ready ||
          drop_cnt_out !== 16'(e_drop16) || repeat_cnt_out !== 16'(e_rep16) ||
          s_data_valid_out !== m_valid || s_drop_cnt_out !== 2'(e_drop2) || s_repeat_cnt_out !== 2'(e_rep2)) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%0b sof=%0b d=%0h rdy=%0b drop=%0d rep=%0d sdrop=%0d srep=%0d, expected v=%0b sof=%0b d=%0h rdy=%0b drop=%0d rep=%0d sdrop=%0d srep=%0d",
                 c, data_valid_out, rd_sof_out, data_out, frame_ready_out, drop_cnt_out, repeat_cnt_out, s_drop_cnt_out, s_repeat_cnt_out,
                 m_valid, m_sof, m_data, m_ready, e_drop16, e_rep16, e_drop2, e_rep2);
      end
    end
  endtask

  initial begin
    reset = 1'b1; wr_en_in = 1'b0; wr_sof_in = 1'b0; rd_en_in = 1'b0; data_in = '0;
    m_wpos = 0; m_rpos = 0; m_drop = 0; m_rep = 0;
    m_pv = 0; m_ready = 0; m_valid = 0; m_sof = 0; m_data = '0;
    test_reset();
    test_basic();
    test_drop();
    test_abort();
    test_simultaneous();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units, expected completion");
    $fatal(1, "timeout");
  end

endmodule
